// File: rtl/arbiter_game_referee_pkg.sv
// Shared definitions for the match referee: state encodings, default timing
// constants and the per-cycle round event classifier.
package arbiter_game_referee_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARM       = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_MATCH_END = 3'd4;

    localparam int unsigned DEF_ROUNDS_TO_WIN = 3;
    localparam int unsigned DEF_SCORE_W       = 2;
    localparam int unsigned DEF_PAUSE_CYCLES  = 12_000_000;
    localparam int unsigned DEF_PAUSE_W       = 24;

    typedef struct packed {
        logic hit;
        logic point1;
        logic point2;
        logic foul1;
        logic foul2;
    } round_eval_t;

    // False starts during the countdown outrank grants; a tie is a void round.
    function automatic round_eval_t eval_round(
        input logic cd_active,
        input logic req1,
        input logic req2,
        input logic gnt1,
        input logic gnt2
    );
        round_eval_t r;
        r = '0;
        if (cd_active && (req1 || req2)) begin
            r.hit    = 1'b1;
            r.foul1  = req1;
            r.foul2  = req2;
            r.point1 = req2 && !req1;
            r.point2 = req1 && !req2;
        end else if (!cd_active && (gnt1 || gnt2)) begin
            r.hit    = 1'b1;
            r.point1 = gnt1 && !gnt2;
            r.point2 = gnt2 && !gnt1;
        end
        return r;
    endfunction

endpackage

// File: rtl/referee_pause_timer.sv
// Loadable down-counter timing the pause between rounds.
module referee_pause_timer
    import arbiter_game_referee_pkg::*;
#(
    parameter int unsigned PAUSE_CYCLES = DEF_PAUSE_CYCLES,
    parameter int unsigned PAUSE_W      = DEF_PAUSE_W
) (
    input  logic clk,
    input  logic rst_in_n,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [PAUSE_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= PAUSE_W'(PAUSE_CYCLES);
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - PAUSE_W'(1);
        end
    end

    assign done = en && (count_q == PAUSE_W'(1));

endmodule

// File: rtl/arbiter_game_referee.sv
// Match-level referee: sequences game FSM rounds, scores them, flags false
// starts and declares the first player to ROUNDS_TO_WIN the match winner.
module arbiter_game_referee
    import arbiter_game_referee_pkg::*;
#(
    parameter int unsigned ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
    parameter int unsigned SCORE_W       = DEF_SCORE_W,
    parameter int unsigned PAUSE_CYCLES  = DEF_PAUSE_CYCLES,
    parameter int unsigned PAUSE_W       = DEF_PAUSE_W
) (
    input  logic               clk,
    input  logic               rst_in_n,
    input  logic               start_in,
    input  logic               req1,
    input  logic               req2,
    input  logic               cd_active_in,
    input  logic               gnt1_in,
    input  logic               gnt2_in,
    output logic               game_rst_n_out,
    output logic [SCORE_W-1:0] score1_out,
    output logic [SCORE_W-1:0] score2_out,
    output logic               foul1_out,
    output logic               foul2_out,
    output logic               match_win1_out,
    output logic               match_win2_out,
    output logic               busy_out
);

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

    logic [2:0]         state_q;
    logic [2:0]         state_nxt;
    logic [SCORE_W-1:0] score1_nxt;
    logic [SCORE_W-1:0] score2_nxt;
    logic               foul1_nxt;
    logic               foul2_nxt;
    logic               win1_nxt;
    logic               win2_nxt;
    logic               busy_nxt;
    logic               game_rst_n_nxt;
    logic               pause_load_c;
    logic               pause_en_c;
    logic               pause_done_c;
    round_eval_t        ev_c;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN_SCORE) ? WIN_SCORE : s + SCORE_W'(1);
    endfunction

    assign pause_en_c = (state_q == ST_PAUSE);

    referee_pause_timer #(
        .PAUSE_CYCLES (PAUSE_CYCLES),
        .PAUSE_W      (PAUSE_W)
    ) u_pause_timer (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .load     (pause_load_c),
        .en       (pause_en_c),
        .done     (pause_done_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            state_q        <= ST_IDLE;
            score1_out     <= '0;
            score2_out     <= '0;
            foul1_out      <= 1'b0;
            foul2_out      <= 1'b0;
            match_win1_out <= 1'b0;
            match_win2_out <= 1'b0;
            busy_out       <= 1'b0;
            game_rst_n_out <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            score1_out     <= score1_nxt;
            score2_out     <= score2_nxt;
            foul1_out      <= foul1_nxt;
            foul2_out      <= foul2_nxt;
            match_win1_out <= win1_nxt;
            match_win2_out <= win2_nxt;
            busy_out       <= busy_nxt;
            game_rst_n_out <= game_rst_n_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state_q;
        score1_nxt   = score1_out;
        score2_nxt   = score2_out;
        foul1_nxt    = foul1_out;
        foul2_nxt    = foul2_out;
        win1_nxt     = match_win1_out;
        win2_nxt     = match_win2_out;
        pause_load_c = 1'b0;
        ev_c         = eval_round(cd_active_in, req1, req2, gnt1_in, gnt2_in);

        case (state_q)
            ST_IDLE, ST_MATCH_END: begin
                if (start_in) begin
                    state_nxt  = ST_ARM;
                    score1_nxt = '0;
                    score2_nxt = '0;
                    foul1_nxt  = 1'b0;
                    foul2_nxt  = 1'b0;
                    win1_nxt   = 1'b0;
                    win2_nxt   = 1'b0;
                end
            end
            ST_ARM: begin
                state_nxt = ST_PLAY;
                foul1_nxt = 1'b0;
                foul2_nxt = 1'b0;
            end
            ST_PLAY: begin
                if (ev_c.hit) begin
                    foul1_nxt = ev_c.foul1;
                    foul2_nxt = ev_c.foul2;
                    if (ev_c.point1) begin
                        score1_nxt = sat_inc(score1_out);
                    end
                    if (ev_c.point2) begin
                        score2_nxt = sat_inc(score2_out);
                    end
                    if (score1_nxt == WIN_SCORE) begin
                        state_nxt = ST_MATCH_END;
                        win1_nxt  = 1'b1;
                    end else if (score2_nxt == WIN_SCORE) begin
                        state_nxt = ST_MATCH_END;
                        win2_nxt  = 1'b1;
                    end else begin
                        state_nxt    = ST_PAUSE;
                        pause_load_c = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_done_c) begin
                    state_nxt = ST_ARM;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt       = (state_nxt != ST_IDLE) && (state_nxt != ST_MATCH_END);
        game_rst_n_nxt = (state_nxt == ST_PLAY);
    end

endmodule

// File: tb/tb_arbiter_game_referee.sv
// Scoreboarded random bench for arbiter_game_referee (ROUNDS_TO_WIN=2, PAUSE_CYCLES=4).
module tb_arbiter_game_referee;

    localparam int unsigned RTW   = 2;
    localparam int unsigned SW    = 2;
    localparam int unsigned PAUSE = 4;
    localparam int unsigned PW    = 3;

    logic          clk = 1'b0;
    logic          rst_in_n;
    logic          start_in;
    logic          req1;
    logic          req2;
    logic          cd_active_in;
    logic          gnt1_in;
    logic          gnt2_in;
    logic          game_rst_n_out;
    logic [SW-1:0] score1_out;
    logic [SW-1:0] score2_out;
    logic          foul1_out;
    logic          foul2_out;
    logic          match_win1_out;
    logic          match_win2_out;
    logic          busy_out;

    arbiter_game_referee #(
        .ROUNDS_TO_WIN (RTW),
        .SCORE_W       (SW),
        .PAUSE_CYCLES  (PAUSE),
        .PAUSE_W       (PW)
    ) dut (
        .clk            (clk),
        .rst_in_n       (rst_in_n),
        .start_in       (start_in),
        .req1           (req1),
        .req2           (req2),
        .cd_active_in   (cd_active_in),
        .gnt1_in        (gnt1_in),
        .gnt2_in        (gnt2_in),
        .game_rst_n_out (game_rst_n_out),
        .score1_out     (score1_out),
        .score2_out     (score2_out),
        .foul1_out      (foul1_out),
        .foul2_out      (foul2_out),
        .match_win1_out (match_win1_out),
        .match_win2_out (match_win2_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic          f1;
        logic          f2;
        logic          w1;
        logic          w2;
        logic          busy;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   directed_q[$];

    // Reference model of the match, updated by round outcome rules.
    int   m_s1, m_s2;
    bit   m_over;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every fall of game_rst_n_out ends a round (or a match, or a reset).
    logic prev_grst = 1'b0;
    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        if (prev_grst && !game_rst_n_out) begin
            act = '{score1_out, score2_out, foul1_out, foul2_out,
                    match_win1_out, match_win2_out, busy_out};
            if (exp_q.size() == 0) begin
                check("unexpected_round_end", 1, 0);
            end else begin
                exp = exp_q.pop_front();
                check("round_result", int'(act), int'(exp));
            end
        end
        prev_grst <= game_rst_n_out;
    end

    task automatic clear_inputs();
        start_in = 1'b0; req1 = 1'b0; req2 = 1'b0;
        cd_active_in = 1'b0; gnt1_in = 1'b0; gnt2_in = 1'b0;
    endtask

    task automatic start_match();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        m_s1 = 0; m_s2 = 0; m_over = 1'b0;
        check("arm_grst_low", int'(game_rst_n_out), 0);
        check("arm_scores_clear", int'({score1_out, score2_out}), 0);
        check("arm_busy", int'(busy_out), 1);
        check("arm_wins_clear", int'({match_win1_out, match_win2_out}), 0);
        @(negedge clk);
        check("play_grst_rise", int'(game_rst_n_out), 1);
        check("play_fouls_clear", int'({foul1_out, foul2_out}), 0);
    endtask

    function automatic int next_kind();
        if (directed_q.size() != 0) return directed_q.pop_front();
        return int'($urandom_range(0, 5));
    endfunction

    task automatic drive_reset_in_play();
        rst_in_n = 1'b0;
        exp_q.push_back('0);
        @(negedge clk);
        rst_in_n = 1'b1;
        m_s1 = 0; m_s2 = 0; m_over = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'({game_rst_n_out, busy_out, score1_out, score2_out}), 0);
    endtask

    // Plays one round from a PLAY negedge; kind 6 is a mid-match reset.
    task automatic play_round(input int kind);
        bit ev_f1, ev_f2, p1, p2;
        int low;
        repeat ($urandom_range(0, 3)) begin
            start_in = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cd_active_in = 1'b1; req1 = 1'b0; req2 = 1'b0;
                gnt1_in = 1'b0; gnt2_in = 1'b0;
            end else begin
                cd_active_in = 1'b0; req1 = 1'($urandom); req2 = 1'($urandom);
                gnt1_in = 1'b0; gnt2_in = 1'b0;
            end
            @(negedge clk);
            check("no_event_in_noise", int'(game_rst_n_out), 1);
        end
        clear_inputs();
        if (kind == 6) begin
            drive_reset_in_play();
            return;
        end
        ev_f1 = 1'b0; ev_f2 = 1'b0; p1 = 1'b0; p2 = 1'b0;
        case (kind)
            0: begin gnt1_in = 1'b1; p1 = 1'b1; end
            1: begin gnt2_in = 1'b1; p2 = 1'b1; end
            2: begin gnt1_in = 1'b1; gnt2_in = 1'b1; end
            3: begin cd_active_in = 1'b1; req1 = 1'b1; ev_f1 = 1'b1; p2 = 1'b1; end
            4: begin cd_active_in = 1'b1; req2 = 1'b1; ev_f2 = 1'b1; p1 = 1'b1; end
            default: begin cd_active_in = 1'b1; req1 = 1'b1; req2 = 1'b1;
                           ev_f1 = 1'b1; ev_f2 = 1'b1; end
        endcase
        if (kind <= 2) begin
            req1 = 1'($urandom); req2 = 1'($urandom);
        end
        if (p1 && m_s1 < int'(RTW)) m_s1++;
        if (p2 && m_s2 < int'(RTW)) m_s2++;
        m_over = (m_s1 == int'(RTW)) || (m_s2 == int'(RTW));
        exp_q.push_back('{SW'(m_s1), SW'(m_s2), ev_f1, ev_f2,
                          m_s1 == int'(RTW), m_s2 == int'(RTW), !m_over});
        @(negedge clk);
        clear_inputs();
        if (m_over) begin
            repeat (2) @(negedge clk);
            check("match_end_grst", int'(game_rst_n_out), 0);
            check("match_end_busy", int'(busy_out), 0);
            return;
        end
        low = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) gnt2_in = 1'b1;
            if (i == 3) gnt2_in = 1'b0;
            @(negedge clk);
            if (game_rst_n_out) break;
            low++;
        end
        gnt2_in = 1'b0;
        check("pause_low_cycles", low, int'(PAUSE) + 1);
        if (!game_rst_n_out) begin
            $display("FAIL round_restart_timeout: got no rise, expected rise");
            $fatal(1, "stuck in pause");
        end
        check("next_round_scores", int'({score1_out, score2_out}), int'({SW'(m_s1), SW'(m_s2)}));
        check("next_round_fouls", int'({foul1_out, foul2_out}), 0);
    endtask

    initial begin
        clear_inputs();
        rst_in_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({game_rst_n_out, score1_out, score2_out, foul1_out, foul2_out,
                                     match_win1_out, match_win2_out, busy_out}), 0);
        rst_in_n = 1'b1;
        @(negedge clk);
        check("idle_holds", int'({game_rst_n_out, busy_out}), 0);

        // Clean match, false-start/void/reset match, then random matches.
        directed_q = '{0, 0, 4, 5, 2, 6};
        for (int m = 0; m < 8; m++) begin
            start_match();
            for (int r = 0; r < 40; r++) begin
                play_round(next_kind());
                if (m_over) break;
            end
            if (!m_over) drive_reset_in_play();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
